// File: rtl/vram_write_queue_m.sv
// CPU-to-VRAM write buffer: queues CPU writes in order and replays them into the GPU port while VRAM is writable.
// Drain is combinational from the head entry; writes arriving while full are dropped and flagged sticky.
module vram_write_queue_m #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            cpu_data_in,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic                  cpu_write_enable,
   input  logic                  SELECT_vram,
   input  logic                  SELECT_vram_queue_status,
   inout  wire  [7:0]            data_out,
   input  logic                  writable,
   output logic [7:0]            gpu_data_in,
   output logic [ADDR_WIDTH-1:0] gpu_address,
   output logic                  gpu_write_enable,
   output logic                  queue_full
);

   localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         ENT_W   = ADDR_WIDTH + 8;
   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [4:0]       count_q, count_d;
   logic             overflow_q, overflow_d;

   logic             push, pop, drop, clr, empty;
   logic [ENT_W-1:0] head_entry;
   logic [7:0]       status;

   assign empty      = (count_q == 5'd0);
   assign queue_full = (count_q == DEPTH_C);
   assign head_entry = mem_q[head_q];

   // Full test uses the pre-edge count, so a same-cycle pop never rescues a write.
   assign push = cpu_write_enable && SELECT_vram && !queue_full;
   assign drop = cpu_write_enable && SELECT_vram && queue_full;
   assign clr  = cpu_write_enable && SELECT_vram_queue_status;
   assign pop  = writable && !empty;

   assign gpu_write_enable = pop;
   assign gpu_address      = pop ? head_entry[ENT_W-1:8] : '0;
   assign gpu_data_in      = pop ? head_entry[7:0]       : '0;

   assign status   = {overflow_q, queue_full, empty, count_q};
   assign data_out = SELECT_vram_queue_status ? status : 8'bz;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 5'd1;
      else if (pop && !push) count_d = count_q - 5'd1;
      if (drop)     overflow_d = 1'b1;
      else if (clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= {cpu_address, cpu_data_in};
   end

endmodule

// File: tb/tb_vram_write_queue_m.sv
// Directed bench for vram_write_queue_m: burst, overflow, pass-through, partial window, full+pop, reset mid-drain.
module tb_vram_write_queue_m;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    cpu_data_in;
   logic [AW-1:0] cpu_address;
   logic          cpu_write_enable;
   logic          SELECT_vram;
   logic          SELECT_vram_queue_status;
   wire  [7:0]    data_out;
   logic          writable;
   logic [7:0]    gpu_data_in;
   logic [AW-1:0] gpu_address;
   logic          gpu_write_enable;
   logic          queue_full;

   int n_chk  = 0;
   int n_fail = 0;
   logic [AW+7:0] gw_q [$];

   vram_write_queue_m #(.DEPTH(16), .ADDR_WIDTH(AW)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .cpu_data_in              (cpu_data_in),
      .cpu_address              (cpu_address),
      .cpu_write_enable         (cpu_write_enable),
      .SELECT_vram              (SELECT_vram),
      .SELECT_vram_queue_status (SELECT_vram_queue_status),
      .data_out                 (data_out),
      .writable                 (writable),
      .gpu_data_in              (gpu_data_in),
      .gpu_address              (gpu_address),
      .gpu_write_enable         (gpu_write_enable),
      .queue_full               (queue_full)
   );

   always #5 clk = ~clk;

   // Inputs only change just after posedge, so the negedge value is what the next edge consumes.
   always @(negedge clk) begin
      if (gpu_write_enable) gw_q.push_back({gpu_address, gpu_data_in});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
      cpu_address      = a;
      cpu_data_in      = d;
      cpu_write_enable = 1'b1;
      SELECT_vram      = 1'b1;
      tick();
      cpu_write_enable = 1'b0;
      SELECT_vram      = 1'b0;
   endtask

   task automatic rd_status(input string tag, input logic [7:0] exp);
      SELECT_vram_queue_status = 1'b1;
      #1;
      check(tag, {24'd0, data_out}, {24'd0, exp});
      SELECT_vram_queue_status = 1'b0;
   endtask

   task automatic clear_ovf();
      cpu_write_enable         = 1'b1;
      SELECT_vram_queue_status = 1'b1;
      tick();
      cpu_write_enable         = 1'b0;
      SELECT_vram_queue_status = 1'b0;
   endtask

   task automatic check_gw(input string tag, input int base_idx, input logic [AW-1:0] a0,
                           input logic [7:0] d0, input int n);
      logic [AW+7:0] e;
      for (int i = 0; i < n; i++) begin
         e = {a0 + AW'(i), d0 + 8'(i)};
         if (base_idx + i < gw_q.size()) check(tag, 32'(gw_q[base_idx + i]), 32'(e));
         else check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
      end
   endtask

   initial begin
      rst = 1'b1;
      cpu_data_in = '0; cpu_address = '0; cpu_write_enable = 1'b0;
      SELECT_vram = 1'b0; SELECT_vram_queue_status = 1'b0; writable = 1'b0;
      tick();
      check("rst_gwe", 32'(gpu_write_enable), 0);
      check("rst_gaddr", 32'(gpu_address), 0);
      check("rst_gdata", 32'(gpu_data_in), 0);
      check("rst_full", 32'(queue_full), 0);
      rd_status("rst_status", 8'h20);
      rst = 1'b0;
      tick();

      // Active-video burst
      for (int i = 0; i < 15; i++) push(AW'(16'h0100 + i), 8'(8'hA0 + i));
      check("burst_full15", 32'(queue_full), 0);
      push(15'h010F, 8'hAF);
      check("burst_full16", 32'(queue_full), 1);
      check("burst_no_gwe", gw_q.size(), 0);
      rd_status("burst_status", 8'h50);
      writable = 1'b1;
      #1;
      check("drain_gwe_rise", 32'(gpu_write_enable), 1);
      check("drain_head_addr", 32'(gpu_address), 32'h0100);
      check("drain_head_data", 32'(gpu_data_in), 32'hA0);
      repeat (16) tick();
      check("drain_empty_gwe", 32'(gpu_write_enable), 0);
      check("drain_empty_addr", 32'(gpu_address), 0);
      writable = 1'b0;
      check("drain_count", gw_q.size(), 16);
      check_gw("drain_order", 0, 15'h0100, 8'hA0, 16);
      rd_status("drain_status", 8'h20);
      gw_q.delete();

      // Overflow, clear, and same-cycle clear+overflow
      for (int i = 0; i < 16; i++) push(AW'(16'h0180 + i), 8'(8'h10 + i));
      push(15'h0200, 8'hEE);
      rd_status("ovf_status", 8'hD0);
      clear_ovf();
      rd_status("ovf_cleared", 8'h50);
      cpu_write_enable = 1'b1; SELECT_vram = 1'b1; SELECT_vram_queue_status = 1'b1;
      cpu_address = 15'h0201; cpu_data_in = 8'hEF;
      tick();
      cpu_write_enable = 1'b0; SELECT_vram = 1'b0; SELECT_vram_queue_status = 1'b0;
      rd_status("ovf_set_wins", 8'hD0);
      writable = 1'b1;
      repeat (16) tick();
      writable = 1'b0;
      check("ovf_drain_count", gw_q.size(), 16);
      check_gw("ovf_drain_order", 0, 15'h0180, 8'h10, 16);
      clear_ovf();
      rd_status("ovf_final", 8'h20);
      gw_q.delete();

      // Pass-through in vblank
      writable = 1'b1;
      push(15'h0300, 8'h11);
      check("pt_gwe", 32'(gpu_write_enable), 1);
      check("pt_addr", 32'(gpu_address), 32'h0300);
      check("pt_data", 32'(gpu_data_in), 32'h11);
      tick();
      rd_status("pt_empty", 8'h20);
      check("pt_count", gw_q.size(), 1);
      gw_q.delete();
      for (int i = 0; i < 4; i++) begin
         cpu_write_enable = 1'b1; SELECT_vram = 1'b1;
         cpu_address = AW'(16'h0310 + i); cpu_data_in = 8'(8'h20 + i);
         tick();
         rd_status("stream_count1", 8'h01);
      end
      cpu_write_enable = 1'b0; SELECT_vram = 1'b0;
      tick();
      rd_status("stream_done", 8'h20);
      writable = 1'b0;
      check("stream_gw_count", gw_q.size(), 4);
      check_gw("stream_order", 0, 15'h0310, 8'h20, 4);
      gw_q.delete();

      // Window closes mid-drain
      for (int i = 0; i < 10; i++) push(AW'(16'h0500 + i), 8'(8'h50 + i));
      writable = 1'b1;
      repeat (4) tick();
      writable = 1'b0;
      check("partial_count", gw_q.size(), 4);
      rd_status("partial_status", 8'h06);
      writable = 1'b1;
      repeat (6) tick();
      writable = 1'b0;
      check("partial_total", gw_q.size(), 10);
      check_gw("partial_order", 0, 15'h0500, 8'h50, 10);
      gw_q.delete();

      // Full with simultaneous pop
      for (int i = 0; i < 16; i++) push(AW'(16'h0400 + i), 8'(8'h60 + i));
      writable = 1'b1;
      cpu_write_enable = 1'b1; SELECT_vram = 1'b1;
      cpu_address = 15'h04FF; cpu_data_in = 8'hFF;
      tick();
      cpu_write_enable = 1'b0; SELECT_vram = 1'b0;
      rd_status("fullpop_status", 8'h8F);
      repeat (15) tick();
      writable = 1'b0;
      check("fullpop_count", gw_q.size(), 16);
      check_gw("fullpop_order", 0, 15'h0400, 8'h60, 16);
      clear_ovf();
      gw_q.delete();

      // Async reset mid-drain
      for (int i = 0; i < 8; i++) push(AW'(16'h0600 + i), 8'(8'h70 + i));
      writable = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      check("arst_gwe", 32'(gpu_write_enable), 0);
      rd_status("arst_status", 8'h20);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("arst_gwe_after", 32'(gpu_write_enable), 0);
      check("arst_gw_count", gw_q.size(), 1);
      writable = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_write_queue_m.md
# vram_write_queue_m

CPU-side write buffer placed directly upstream of the GPU's VRAM write port. It accepts CPU VRAM writes at any time, stores them in order in a small FIFO, and replays them into the GPU only while the GPU reports VRAM as writable (vblank). The CPU therefore never loses a write issued during active video. A status byte exposes queue fill and a sticky overflow flag on the shared data bus.

## Interface
Parameters:
- DEPTH, 16, number of queued writes; power of two, 2..16.
- ADDR_WIDTH, 15, VRAM address width; instantiated with the project's VRAM address width.

Ports:
- clk  in  1  system clock, 12.5875 MHz.
- rst  in  1  reset, asynchronous, active-high.
- cpu_data_in  in  8  CPU write data.
- cpu_address  in  ADDR_WIDTH  CPU VRAM address.
- cpu_write_enable  in  1  CPU write strobe; one write per cycle high.
- SELECT_vram  in  1  CPU is addressing VRAM.
- SELECT_vram_queue_status  in  1  CPU is addressing the queue status byte, for read or for clear.
- data_out  inout  8  status byte when SELECT_vram_queue_status is high; otherwise high-Z.
- writable  in  1  GPU VRAM write window, high during vblank.
- gpu_data_in  out  8  data to the GPU VRAM port.
- gpu_address  out  ADDR_WIDTH  address to the GPU VRAM port.
- gpu_write_enable  out  1  GPU VRAM write strobe.
- queue_full  out  1  count == DEPTH.

## Operation
- Enqueue condition: `cpu_write_enable && SELECT_vram && !queue_full`, evaluated on the pre-edge state.
  - On enqueue, {address, data} is stored at the tail; the tail pointer and count advance on the clk rising edge.
- Drop rule: a write that meets the enqueue condition except `queue_full` is dropped.
  - The sticky `overflow` flag is set.
  - This holds even if a pop happens in the same cycle. The full test uses the pre-edge count only.
- Drain path (combinational):
  - `gpu_write_enable = writable && (count != 0)`.
  - gpu_address and gpu_data_in carry the head entry while gpu_write_enable is high. Otherwise they are driven to 0.
  - Pop (head pointer advances, count decrements) on every rising edge where gpu_write_enable is high.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Order: strict FIFO; no coalescing of writes to the same address.
- Status byte on data_out: {overflow, queue_full, empty, count[4:0]}.
  - empty = (count == 0).
  - Driven combinationally whenever SELECT_vram_queue_status is high.
- Overflow clear: `cpu_write_enable && SELECT_vram_queue_status` clears overflow. If an overflow event occurs in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is 5 bits, range 0..DEPTH.
- Storage: register array or distributed RAM with combinational read; no reset of array contents is required.

## Timing
- Reset (async assert, state cleared immediately):
  - head = tail = count = 0, overflow = 0.
  - gpu_write_enable = 0, gpu_address = 0, gpu_data_in = 0, queue_full = 0.
  - Status byte = 8'b0010_0000.
- Reset mid-drain: all queued entries are discarded. gpu_write_enable drops in the same cycle that rst asserts.
- Latency: a write accepted at edge N is visible on the GPU port during cycle N..N+1 if writable is high and it is at the head. The GPU consumes it at edge N+1.
  - Minimum CPU-to-GPU latency is 1 clock.
- Throughput: one drain per clock while writable is high.
  - DEPTH entries drain in DEPTH clocks, well inside the vblank window.
- writable falling: gpu_write_enable falls in the same cycle and no pop occurs. Remaining entries wait for the next window.
- writable rising with a non-empty queue: gpu_write_enable rises in the same cycle.
- The block introduces no extra pipeline stage. The GPU sees the write strobe and data in the same cycle as writable.

## Test plan
- Active-video burst:
  - Stimulus: writable=0; CPU writes 16 entries (addr 0x0100+i, data 0xA0+i).
  - Required during the burst: no gpu_write_enable; queue_full=1 after the 16th; status byte = 0x50.
  - Then raise writable: 16 consecutive gpu writes in order, 0x0100/0xA0 … 0x010F/0xAF. Status returns to 0x20.
- Overflow:
  - Stimulus: writable=0; queue full; 17th write to addr 0x0200.
  - Required: write dropped, overflow=1, status byte = 0xD0.
  - Then a write with SELECT_vram_queue_status: overflow clears, status byte = 0x50.
  - Same-cycle clear plus overflow: overflow stays 1.
- Pass-through in vblank:
  - Stimulus: writable=1; single write at edge N.
  - Required: gpu_write_enable high in cycle N..N+1; queue empty after edge N+1.
  - Simultaneous push and pop each cycle: count stays at 1 for a continuous stream.
- Window closes mid-drain:
  - Stimulus: 10 queued; writable high for 4 clocks.
  - Required: exactly 4 GPU writes; status byte count = 6. The next window delivers entries 5..10 in order.
- Full with simultaneous pop:
  - Stimulus: queue full, writable=1, CPU write in the same cycle.
  - Required: the write is dropped, overflow=1, count=15 after the edge.
- Async reset mid-drain:
  - Stimulus: 8 queued, writable=1; assert rst between edges.
  - Required: gpu_write_enable=0 immediately; status byte 0x20; no further GPU writes after release.
